clkdiv_fractional: RTL and testbench
====================================

CLKDIV_FRACTIONAL -- requirements
Module: clkdiv_fractional

Interface
REQ-001 SHALL have parameter INT_W, default 8, width of the integer divide ratio.
REQ-002 SHALL have parameter FRAC_W, default 2, width of the fractional divide ratio, in units of 1/2^FRAC_W (quarters at default).
REQ-003 SHALL have port clkin  input  1  the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous, active-high reset (asserted when 1, despite the name).
REQ-005 SHALL have port en  input  1  divider enable.
REQ-006 SHALL have port int_div  input  INT_W  integer part of the divide ratio.
REQ-007 SHALL have port frac_div  input  FRAC_W  fractional part of the divide ratio.
REQ-008 SHALL have port clkout  output  1  divided clock, driven directly from a flop (glitch-free).

Function
REQ-009 Average clkout period SHALL be (int_div + frac_div/2^FRAC_W) clkin cycles; int_div=3, frac_div=1 -> 3.25 cycles.
REQ-010 SHALL keep a FRAC_W-bit phase accumulator ACC; at each output-period start, {carry, ACC} <= ACC + frac_div.
REQ-011 Period length P SHALL be N + carry clkin cycles, where N = max(int_div, 2); int_div values 0 and 1 are clamped to 2.
REQ-012 SHALL keep a period counter k counting 0..P-1, then wrapping to 0 and starting a new period.
REQ-013 clkout SHALL be 1 for k < floor(P/2) and 0 for the remaining P - floor(P/2) cycles of each period; the longer half is low.
REQ-014 int_div and frac_div SHALL be sampled only at period start; a mid-period change takes effect from the next period.
REQ-015 With en=0, clkout SHALL be 0 and k and ACC SHALL hold 0 from the next clkin edge.
REQ-016 On en 0->1, the first period SHALL start at the next clkin edge with ACC=0.
REQ-017 frac_div=0 SHALL give an exact integer divide, with constant P = N.
REQ-018 For frac_div=f, exactly f of every 2^FRAC_W consecutive periods SHALL be N+1 cycles long.

Reset
REQ-019 While rstn=1, clkout, k and ACC SHALL be 0, forced asynchronously with no clkin edge required.
REQ-020 After rstn falls, the first period SHALL start at the first clkin edge where en=1.
REQ-021 Asserting rstn mid-period SHALL abort the period immediately, with clkout 0; there is no partial-period recovery.

Structure
REQ-022 Shared package clkdiv_pkg SHALL hold INT_W_DEF=8, FRAC_W_DEF=2 and the min-ratio constant MIN_INT_DIV=2.
REQ-023 The accumulator/carry logic SHALL be a sub-module clkdiv_frac_acc (inputs: frac_div, period-start strobe; output: carry); the rest SHALL be flat.
REQ-024 No combinational path SHALL exist from clkin or any input to clkout.

Verification
REQ-025 1 GHz clkin, int_div=3, frac_div=1, en=1, rstn pulsed for 10 cycles: period sequence SHALL be 3,3,3,4 repeating; after 50 clkout edges, frequency measured over a 4-period window SHALL be 1e9/3.25 Hz within tolerance.
REQ-026 int_div=4, frac_div=0: clkout SHALL be 2 high and 2 low, with every period 4 cycles.
REQ-027 int_div=2, frac_div=2: periods SHALL alternate 2,3 (high 1 each), averaging 2.5 cycles.
REQ-028 int_div=0 or 1, frac_div=0: clkout SHALL be the clkin/2 square wave.
REQ-029 Drop en mid-period: clkout SHALL be 0 by the next edge; re-raise en: clkout SHALL restart with a fresh 3,3,3,4 sequence.
REQ-030 Assert rstn between clkin edges while clkout=1: clkout SHALL drop to 0 immediately.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared defaults for the fractional clock divider
`timescale 1ns/1ps
package clkdiv_pkg;
   localparam int INT_W_DEF   = 8;
   localparam int FRAC_W_DEF  = 2;
   localparam int MIN_INT_DIV = 2;
endpackage

// File: rtl/clkdiv_frac_acc.sv
// rtl/clkdiv_frac_acc.sv - fractional phase accumulator; carry stretches a period by one cycle
`timescale 1ns/1ps
module clkdiv_frac_acc
   import clkdiv_pkg::*;
#(
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              start,
   input  logic [FRAC_W-1:0] frac_div,
   output logic              carry
);

   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [FRAC_W:0]   sum;

   // carry is valid combinationally so the top can size the period being started
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, frac_div};
      carry = sum[FRAC_W];
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (start) begin
         acc_d = sum[FRAC_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/clkdiv_fractional.sv
// rtl/clkdiv_fractional.sv - fractional-N clock divider, average period int_div + frac_div/2^FRAC_W
`timescale 1ns/1ps
module clkdiv_fractional
   import clkdiv_pkg::*;
#(
   parameter int INT_W  = INT_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic              clkin,
   input  logic              rstn,
   input  logic              en,
   input  logic [INT_W-1:0]  int_div,
   input  logic [FRAC_W-1:0] frac_div,
   output logic              clkout
);

   // one extra bit so N + carry never overflows
   localparam int CW = INT_W + 1;

   logic [CW-1:0] k_q, k_d;
   logic [CW-1:0] p_q, p_d;
   logic [CW-1:0] n_ext, p_new;
   logic          run_q, run_d;
   logic          clkout_q, clkout_d;
   logic          start;
   logic          carry;

   clkdiv_frac_acc #(
      .FRAC_W (FRAC_W)
   ) u_acc (
      .clk      (clkin),
      .rst      (rstn),
      .clr      (!en),
      .start    (start),
      .frac_div (frac_div),
      .carry    (carry)
   );

   always_comb begin
      n_ext = {1'b0, int_div};
      if (n_ext < CW'(MIN_INT_DIV)) begin
         n_ext = CW'(MIN_INT_DIV);
      end
      p_new = n_ext + CW'(carry);
      start = en && (!run_q || (k_q == p_q - 1'b1));

      k_d      = k_q;
      p_d      = p_q;
      run_d    = run_q;
      clkout_d = clkout_q;
      if (!en) begin
         k_d      = '0;
         p_d      = '0;
         run_d    = 1'b0;
         clkout_d = 1'b0;
      end else if (start) begin
         k_d      = '0;
         p_d      = p_new;
         run_d    = 1'b1;
         clkout_d = (CW'(0) < (p_new >> 1));
      end else begin
         k_d      = k_q + 1'b1;
         clkout_d = (k_d < (p_q >> 1));
      end
   end

   always_ff @(posedge clkin or posedge rstn) begin
      if (rstn) begin
         k_q      <= '0;
         p_q      <= '0;
         run_q    <= 1'b0;
         clkout_q <= 1'b0;
      end else begin
         k_q      <= k_d;
         p_q      <= p_d;
         run_q    <= run_d;
         clkout_q <= clkout_d;
      end
   end

   assign clkout = clkout_q;

endmodule

// File: tb/tb_clkdiv_fractional.sv
// tb/tb_clkdiv_fractional.sv - directed bench for clkdiv_fractional
`timescale 1ns/1ps
module tb_clkdiv_fractional;

   logic       clkin;
   logic       rstn;
   logic       en;
   logic [7:0] int_div;
   logic [1:0] frac_div;
   logic       clkout;

   int total;
   int passed;

   localparam logic [31:0] P3131 = 32'b1001001001100;

   clkdiv_fractional #(
      .INT_W  (8),
      .FRAC_W (2)
   ) dut (
      .clkin    (clkin),
      .rstn     (rstn),
      .en       (en),
      .int_div  (int_div),
      .frac_div (frac_div),
      .clkout   (clkout)
   );

   initial clkin = 1'b0;
   always #0.5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clkin);
      @(negedge clkin);
   endtask

   task automatic cap(input int n, output logic [31:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         tick();
         v = {v[30:0], clkout};
      end
   endtask

   task automatic wait_high(input string tag);
      for (int i = 0; i < 20 && clkout !== 1'b1; i++) tick();
      chk(tag, {31'b0, clkout}, 32'd1);
   endtask

   initial begin
      logic [31:0] v;
      logic        prev;
      int          rises;
      int          cyc;
      total    = 0;
      passed   = 0;
      rstn     = 1'b1;
      en       = 1'b1;
      int_div  = 8'd3;
      frac_div = 2'd1;
      #0.2;
      chk("reset_no_edge", {31'b0, clkout}, 32'd0);

      for (int i = 0; i < 10; i++) tick();
      rstn = 1'b0;
      cap(13, v);
      chk("seq_3_3_3_4_a", v, P3131);
      cap(13, v);
      chk("seq_3_3_3_4_b", v, P3131);

      rises = 0;
      prev  = clkout;
      for (int i = 0; i < 500 && rises < 25; i++) begin
         tick();
         if (!prev && clkout) rises++;
         prev = clkout;
      end
      chk("rise_count_50_edges", rises, 32'd25);
      rises = 0;
      cyc   = 0;
      for (int i = 0; i < 100 && rises < 4; i++) begin
         tick();
         cyc++;
         if (!prev && clkout) rises++;
         prev = clkout;
      end
      chk("window_4_periods_cycles", cyc, 32'd13);

      wait_high("en_drop_wait_high");
      en = 1'b0;
      tick();
      chk("en_drop_low_next_edge", {31'b0, clkout}, 32'd0);
      cap(3, v);
      chk("en_low_hold", v, 32'd0);
      en = 1'b1;
      cap(13, v);
      chk("en_restart_fresh_seq", v, P3131);

      tick();
      int_div  = 8'd4;
      frac_div = 2'd0;
      cap(10, v);
      chk("midperiod_change_div4", v, 32'b0011001100);

      en = 1'b0;
      tick();
      int_div  = 8'd2;
      frac_div = 2'd2;
      en = 1'b1;
      cap(10, v);
      chk("div_2_5_alternate", v, 32'b1010010100);

      en = 1'b0;
      tick();
      int_div  = 8'd0;
      frac_div = 2'd0;
      en = 1'b1;
      cap(6, v);
      chk("div0_clamped", v, 32'b101010);

      en = 1'b0;
      tick();
      int_div = 8'd1;
      en = 1'b1;
      cap(6, v);
      chk("div1_clamped", v, 32'b101010);

      en = 1'b0;
      tick();
      int_div  = 8'd3;
      frac_div = 2'd1;
      en = 1'b1;
      tick();
      tick();
      wait_high("async_rst_wait_high");
      #0.2;
      rstn = 1'b1;
      #0.05;
      chk("async_rst_immediate", {31'b0, clkout}, 32'd0);
      en = 1'b0;
      @(negedge clkin);
      cap(2, v);
      chk("rst_hold_low", v, 32'd0);
      rstn = 1'b0;
      cap(3, v);
      chk("post_rst_wait_en", v, 32'd0);
      en = 1'b1;
      cap(13, v);
      chk("post_rst_fresh_seq", v, P3131);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
